xbar_rr_port_arbiter: RTL

//  Generalised crossbar peripheral port. It arbitrates NUM_CTRL controller requests onto one

---
 rtl/xbar_rr_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/xbar_rr_port_arbiter.sv
// Crossbar peripheral port: round-robin arbitration of controller requests onto one slave,
// with request lock until handshake and an in-order ID FIFO steering responses back.
module xbar_rr_port_arbiter #(
  parameter int                  NUM_CTRL        = 3,
  parameter int                  WORD_ADDR_WIDTH = 16,
  parameter int                  PORT_SEL_BITS   = 2,
  parameter int                  MAX_OUTST       = 4,
  parameter logic [NUM_CTRL-1:0] RO_MASK         = NUM_CTRL'(1)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_CTRL-1:0]                        c_req_i,
  input  logic [NUM_CTRL*WORD_ADDR_WIDTH-1:0]        c_addr_i,
  input  logic [NUM_CTRL-1:0]                        c_wen_i,
  input  logic [NUM_CTRL*32-1:0]                     c_wdata_i,
  input  logic [NUM_CTRL*4-1:0]                      c_be_i,
  output logic [NUM_CTRL-1:0]                        c_gnt_o,
  output logic [NUM_CTRL-1:0]                        c_rvalid_o,
  output logic [31:0]                                c_rdata_o,
  output logic                                       p_req_o,
  output logic [WORD_ADDR_WIDTH-PORT_SEL_BITS-1:0]   p_addr_o,
  output logic                                       p_wen_o,
  output logic [31:0]                                p_wdata_o,
  output logic [3:0]                                 p_be_o,
  input  logic                                       p_ready_i,
  input  logic                                       p_rvalid_i,
  input  logic [31:0]                                p_rdata_i,
  output logic                                       rsp_err_o
);

  localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
  localparam int PA_W  = WORD_ADDR_WIDTH - PORT_SEL_BITS;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [IDX_W-1:0] last_q, last_d;
  logic             lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fifo_mem_q [MAX_OUTST];

  logic [PA_W-1:0]  addr_low  [NUM_CTRL];
  logic [31:0]      wdata_arr [NUM_CTRL];
  logic [3:0]       be_arr    [NUM_CTRL];
  logic [NUM_CTRL*PORT_SEL_BITS-1:0] unused_addr_sel;

  // Split the packed controller buses; the port-select bits were consumed by the decode.
  for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
    assign addr_low[i]  = c_addr_i[i*WORD_ADDR_WIDTH +: PA_W];
    assign wdata_arr[i] = c_wdata_i[i*32 +: 32];
    assign be_arr[i]    = c_be_i[i*4 +: 4];
    assign unused_addr_sel[i*PORT_SEL_BITS +: PORT_SEL_BITS] =
      c_addr_i[i*WORD_ADDR_WIDTH + PA_W +: PORT_SEL_BITS];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [IDX_W-1:0] rr_g, g, head;
  logic             lock_hold, fifo_full, fifo_empty, p_req, hs, push, pop, wr_en;

  always_comb begin
    int  cand;
    logic found;
    rr_g  = last_q;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_CTRL; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_CTRL) cand = cand - NUM_CTRL;
      if (!found && c_req_i[IDX_W'(cand)]) begin
        rr_g  = IDX_W'(cand);
        found = 1'b1;
      end
    end
  end

  // A lock whose owner withdrew its request is ignored so arbitration reruns this cycle.
  assign lock_hold  = lock_vld_q & c_req_i[lock_idx_q];
  assign g          = lock_hold ? lock_idx_q : rr_g;
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
  assign fifo_empty = (cnt_q == '0);
  assign p_req      = (|c_req_i) & (~fifo_full | p_rvalid_i) & ~rst_i;
  assign hs         = p_req & p_ready_i;
  assign push       = hs;
  assign pop        = p_rvalid_i & ~fifo_empty & ~rst_i;
  assign head       = fifo_mem_q[rd_ptr_q];
  assign wr_en      = p_req & ~RO_MASK[g];

  assign p_req_o    = p_req;
  assign p_addr_o   = p_req ? addr_low[g] : '0;
  assign p_wen_o    = wr_en & c_wen_i[g];
  assign p_wdata_o  = wr_en ? wdata_arr[g] : '0;
  assign p_be_o     = wr_en ? be_arr[g] : '0;
  assign c_gnt_o    = hs ? (NUM_CTRL'(1) << g) : '0;
  assign c_rvalid_o = pop ? (NUM_CTRL'(1) << head) : '0;
  assign c_rdata_o  = rst_i ? '0 : p_rdata_i;
  assign rsp_err_o  = p_rvalid_i & fifo_empty & ~rst_i;

  always_comb begin
    last_d     = hs ? g : last_q;
    lock_vld_d = p_req & ~p_ready_i;
    lock_idx_d = g;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d      = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= IDX_W'(NUM_CTRL - 1);
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // ID storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= g;
  end

endmodule
